// File: rtl/cpu_fetch.sv
// Instruction fetch stage: drives the fetch side of the memory controller,
// buffers returned words in a small prefetch queue and hands them to decode
// over a valid/ready handshake. Supports branch redirect with queue flush.
module cpu_fetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [23:0] RESET_PC = 24'h000000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        fetch_en,
  output logic [23:0] fetch_addr,
  output logic        fetch_re,
  input  logic [15:0] dataRead,
  input  logic        needWait,
  input  logic        mem_req,
  input  logic        redirect,
  input  logic [23:0] redirect_pc,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [23:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_DISCARD
  } state_t;

  state_t      state, state_next;
  logic [23:0] pc, pc_next;
  logic [23:0] hold_addr, hold_next;
  logic        start;
  logic        push;
  logic        pop;

  logic [15:0] q_data [DEPTH];
  logic [23:0] q_pc   [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  // New accesses may only begin from FETCH; the rst_n term keeps the bus
  // released while reset is held, independent of the other inputs.
  assign start = rst_n && (state == S_FETCH) && !mem_req && !redirect && (count < FULL);

  assign fetch_re    = fetch_en;
  assign instr_valid = (count != '0);
  assign instr       = q_data[rd_ptr];
  assign instr_pc    = q_pc[rd_ptr];
  assign pop         = instr_valid && instr_ready && !redirect;

  // Next-state, bus outputs and queue push decision.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    hold_next  = hold_addr;
    fetch_en   = 1'b0;
    fetch_addr = pc;
    push       = 1'b0;
    case (state)
      S_FETCH: begin
        fetch_en = start;
        if (redirect) begin
          pc_next = redirect_pc;
        end else if (start) begin
          if (needWait) begin
            state_next = S_WAIT;
          end else begin
            push    = 1'b1;
            pc_next = pc + 24'd1;
          end
        end
      end
      S_WAIT: begin
        fetch_en = 1'b1;
        if (redirect) begin
          pc_next = redirect_pc;
          if (needWait) begin
            // pc is about to change, so keep the in-flight address separately
            hold_next  = pc;
            state_next = S_DISCARD;
          end else begin
            state_next = S_FETCH;
          end
        end else if (!needWait) begin
          push       = 1'b1;
          pc_next    = pc + 24'd1;
          state_next = S_FETCH;
        end
      end
      S_DISCARD: begin
        fetch_en   = 1'b1;
        fetch_addr = hold_addr;
        if (redirect) pc_next = redirect_pc;
        if (!needWait) state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Control state, pc and queue pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      hold_addr <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      hold_addr <= hold_next;
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Queue storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= dataRead;
      q_pc[wr_ptr]   <= fetch_addr;
    end
  end

endmodule

// File: doc/cpu_fetch.md
Name: cpu_fetch

Overview:
Instruction fetch stage with a small prefetch queue. It sits directly upstream of the CPU memory controller and drives its fetch-side request (fetch_en, fetch_addr, fetch_re). It consumes the controller's shared read data and wait response, and delivers 16-bit instruction words with their addresses to decode through a valid/ready handshake. It yields the bus to the memory stage between accesses and supports branch redirect with queue flush.

Parameters:
DEPTH, 4, prefetch queue entries (power of two, 2..16)
RESET_PC, 24'h000000, word address fetched first after reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch_en  out  1  fetch owns the bus this cycle
fetch_addr  out  24  word address of the current fetch
fetch_re  out  1  read strobe; always equal to fetch_en
dataRead  in  16  read data returned by the memory controller
needWait  in  1  bus not ready; hold the current access
mem_req  in  1  memory stage wants the bus; blocks the start of new fetches
redirect  in  1  branch or jump taken; one-cycle pulse
redirect_pc  in  24  new fetch address, valid when redirect=1
instr_valid  out  1  queue head is valid
instr  out  16  queue head instruction
instr_pc  out  24  address of the queue head
instr_ready  in  1  decode accepts the head this cycle

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, queue empty, state=FETCH.
  - fetch_en=0, fetch_re=0, instr_valid=0.
  - instr and instr_pc are unspecified while instr_valid=0.
- States:
  - FETCH: may start an access.
  - WAIT: an access was stalled; hold it.
  - DISCARD: a stalled access was redirected; finish it and drop the data.
- Start condition (FETCH state only): start = !mem_req & !redirect & (count<DEPTH). This is combinational.
  - fetch_en = fetch_re = start in FETCH; forced to 1 in WAIT and DISCARD.
  - fetch_addr = pc in FETCH and WAIT; the latched address in DISCARD.
- Access completes on a clk edge where fetch_en=1 & needWait=0. Zero-wait memory gives one instruction per cycle.
- On completion in FETCH or WAIT:
  - push {dataRead, fetch_addr} into the queue;
  - pc <= pc+1 (24-bit wrap, FFFFFF -> 000000);
  - state <= FETCH.
- fetch_en=1 & needWait=1 in FETCH -> state WAIT.
  - In WAIT, address and strobe are held stable until needWait=0.
  - mem_req is ignored in WAIT and DISCARD (an access is never abandoned mid-cycle).
- Queue:
  - instr_valid = (count!=0); instr and instr_pc come from the head entry.
  - Pop when instr_valid & instr_ready.
  - Push and pop in the same cycle are both allowed; count is unchanged.
  - A push is never attempted when count==DEPTH, since start is blocked.
  - A full queue with a pop that cycle still does not start a fetch; the fetch starts next cycle.
- Redirect (highest priority):
  - Queue is flushed (count=0; instr_valid=0 next cycle).
  - Any same-cycle pop is ignored.
  - pc <= redirect_pc.
  - If in FETCH: no access is started that cycle. Next cycle fetches redirect_pc.
  - If in WAIT and needWait=1: state <= DISCARD.
  - If in WAIT and needWait=0: the completing data is dropped; state <= FETCH.
  - If in DISCARD: pc is updated and the state stays DISCARD.
- DISCARD: on needWait=0 the data is dropped and state <= FETCH; pc is not incremented.
- A reset asserted mid-access returns immediately to the reset state. The bus is released asynchronously (fetch_en=0).
- The queue uses DEPTH-entry storage, log2(DEPTH)-bit read and write pointers that wrap, and a count of log2(DEPTH)+1 bits.

Test Plan:
1. Reset release, needWait=0, instr_ready=1 -> fetch_addr 000000,000001,000002 on consecutive cycles; instr_pc follows one cycle later; instr equals memory contents.
2. instr_ready=0 with DEPTH=4 -> exactly 4 fetches (000000..000003), then fetch_en=0. Raise instr_ready -> heads pop in order; fetching resumes at 000004.
3. needWait=1 for 3 cycles on address 000010 -> fetch_addr holds 000010 with fetch_en=1 for 4 cycles. Only one entry is pushed; the next fetch is 000011.
4. mem_req=1 while in FETCH -> fetch_en=0 for each mem_req cycle. If mem_req rises during WAIT, fetch_en stays 1 until needWait=0, then drops.
5. redirect to 000400 with 3 queued entries while stalled (WAIT, needWait=1) -> instr_valid=0 next cycle; old access held until needWait=0, data not queued; next fetch_addr=000400, first instr_pc=000400.
6. RESET_PC=FFFFFE, free-running -> fetch_addr FFFFFE, FFFFFF, 000000, 000001.
